// File: rtl/cpu_admin_pkg.sv
// Shared constants and state encoding for the CPU admin sequencer.
// Imported by the sequencer top and its helpers.
package cpu_admin_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  localparam logic [REG_IDX_W-1:0] DONE_REG = 5'd31;

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    RELEASE = 3'd1,
    ARMED   = 3'd2,
    RUN     = 3'd3,
    DONE    = 3'd4,
    FAULT   = 3'd5
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop sync, consecutive-high counter, rise pulse.
// Ports: clk, rst (async low), btn raw in; level debounced, pulse 1-cycle.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync    <= '0;
      cnt     <= '0;
      level_d <= 1'b0;
    end else begin
      sync    <= {sync[0], btn};
      level_d <= level;
      // any low sample restarts the qualification window
      if (!sync[1])
        cnt <= '0;
      else if (cnt != CMAX)
        cnt <= cnt + 1'b1;
    end
  end

  assign level = (cnt == CMAX);
  assign pulse = level & ~level_d;

endmodule

// File: rtl/cpu_admin_sequencer.sv
// Owns the CPU register admin port: loads operands, starts and watches a run.
// Ports: buttons/switches in, reg write strobe out, run control and status out.
import cpu_admin_pkg::*;

module cpu_admin_sequencer #(
  parameter int FIRST_REG       = 4,
  parameter int NUM_OPERANDS    = 4,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int RUN_TIMEOUT     = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 input_press,
  input  logic                 start_press,
  input  logic [15:0]          input_num,
  input  logic                 cpu_busy,
  output logic                 reg_we,
  output logic [REG_IDX_W-1:0] reg_i,
  output logic [DATA_W-1:0]    reg_input,
  output logic                 cpu_run,
  output logic [2:0]           state,
  output logic [4:0]           load_cnt,
  output logic [31:0]          run_cycles,
  output logic                 run_done,
  output logic                 timeout
);

  localparam int WD_W =
    (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(RUN_TIMEOUT - 1);
  localparam logic [4:0] N_OPS = 5'(NUM_OPERANDS);
  localparam logic [REG_IDX_W-1:0] BASE =
    REG_IDX_W'(FIRST_REG);

  logic press_q, press_ev;
  logic [2:0] ssync;
  logic start_ev;

  state_e              st_q, st_d;
  logic [4:0]          ld_q, ld_d;
  logic [31:0]         rc_q, rc_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                we_q, we_d;
  logic [REG_IDX_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic                run_q, run_d;
  logic                dn_q, dn_d;
  logic                to_q, to_d;
  logic                seen_q, seen_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_in_btn (
    .clk  (clk),
    .rst  (rst),
    .btn  (input_press),
    .level(press_q),
    .pulse(press_ev)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ssync <= '0;
    else      ssync <= {ssync[1:0], start_press};
  end

  assign start_ev = ssync[1] & ~ssync[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= LOAD;
      ld_q   <= '0;
      rc_q   <= '0;
      wd_q   <= '0;
      we_q   <= 1'b0;
      idx_q  <= '0;
      dat_q  <= '0;
      run_q  <= 1'b0;
      dn_q   <= 1'b0;
      to_q   <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      ld_q   <= ld_d;
      rc_q   <= rc_d;
      wd_q   <= wd_d;
      we_q   <= we_d;
      idx_q  <= idx_d;
      dat_q  <= dat_d;
      run_q  <= run_d;
      dn_q   <= dn_d;
      to_q   <= to_d;
      seen_q <= seen_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    ld_d   = ld_q;
    rc_d   = rc_q;
    wd_d   = wd_q;
    we_d   = 1'b0;
    idx_d  = '0;
    dat_d  = '0;
    run_d  = run_q;
    dn_d   = dn_q;
    to_d   = to_q;
    seen_d = seen_q;
    case (st_q)
      LOAD: begin
        if (press_ev) begin
          we_d  = 1'b1;
          idx_d = BASE + ld_q;
          dat_d = {16'b0, input_num};
          ld_d  = ld_q + 1'b1;
          st_d  = RELEASE;
        end
      end
      RELEASE: begin
        if (!press_q)
          st_d = (ld_q == N_OPS) ? ARMED : LOAD;
      end
      ARMED: begin
        if (start_ev) begin
          st_d   = RUN;
          run_d  = 1'b1;
          rc_d   = '0;
          wd_d   = '0;
          seen_d = 1'b0;
        end
      end
      RUN: begin
        if (rc_q != '1) rc_d = rc_q + 32'd1;
        wd_d = wd_q + 1'b1;
        if (cpu_busy) seen_d = 1'b1;
        // seen_q && !busy is the 1->0 edge: the run
        // ends the first cycle busy is low again
        if (seen_q && !cpu_busy) begin
          st_d  = DONE;
          dn_d  = 1'b1;
          run_d = 1'b0;
        end else if (wd_q == WD_LAST) begin
          st_d  = FAULT;
          to_d  = 1'b1;
          run_d = 1'b0;
        end
      end
      DONE, FAULT: begin
        if (press_ev) begin
          st_d   = LOAD;
          ld_d   = '0;
          rc_d   = '0;
          wd_d   = '0;
          dn_d   = 1'b0;
          to_d   = 1'b0;
          seen_d = 1'b0;
        end
      end
      default: begin
        st_d   = LOAD;
        ld_d   = '0;
        rc_d   = '0;
        wd_d   = '0;
        run_d  = 1'b0;
        dn_d   = 1'b0;
        to_d   = 1'b0;
        seen_d = 1'b0;
      end
    endcase
  end

  assign reg_we     = we_q;
  assign reg_i      = we_q ? idx_q : '0;
  assign reg_input  = we_q ? dat_q : '0;
  assign cpu_run    = run_q;
  assign state      = st_q;
  assign load_cnt   = ld_q;
  assign run_cycles = rc_q;
  assign run_done   = dn_q;
  assign timeout    = to_q;

endmodule
